// File: rtl/palette_colorizer.sv
// Palette-driven VGA pixel colorizer: world map plus stacked icons through a two-stage pipeline.
// Optional icon blinking is built when PALETTE_COLORIZER_BLINK_EN is defined.
`ifndef MFP_N_VGA
`define MFP_N_VGA 4
`endif

module palette_colorizer #(
    parameter int unsigned WORLD_W      = 2,
    parameter int unsigned ICON_W       = 4,
    parameter int unsigned N_ICON       = 2,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic                                              clock,
    input  logic                                              reset_n,
    input  logic                                              video_on,
    input  logic                                              frame_start,
    input  logic [WORLD_W-1:0]                                world_pixel,
    input  logic [N_ICON*ICON_W-1:0]                          icon,
    input  logic                                              wr_en,
    input  logic                                              wr_sel,
    input  logic [((WORLD_W > ICON_W) ? WORLD_W : ICON_W)-1:0] wr_addr,
    input  logic [11:0]                                       wr_data,
    input  logic                                              wr_blink,
    output logic [`MFP_N_VGA*3-1:0]                           VGA
);

    localparam int unsigned WD = 1 << WORLD_W;
    localparam int unsigned ID = 1 << ICON_W;
    localparam int unsigned NV = `MFP_N_VGA;

    function automatic logic [11:0] world_default(int unsigned idx);
        case (idx)
            0:       return 12'hBBB;
            2:       return 12'hF51;
            3:       return 12'hFFF;
            default: return 12'h000;
        endcase
    endfunction

    function automatic logic [11:0] icon_default(int unsigned idx);
        case (idx)
            2:       return 12'h0F0;
            3:       return 12'hF00;
            4:       return 12'h3A6;
            5:       return 12'hF51;
            6:       return 12'h444;
            default: return 12'h000;
        endcase
    endfunction

    logic [11:0]       world_pal [WD];
    logic [11:0]       icon_pal  [ID];
    logic [ICON_W-1:0] icon_code [N_ICON];
    logic [N_ICON-1:0] icon_vis;

`ifdef PALETTE_COLORIZER_BLINK_EN
    localparam int unsigned CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;
    logic [ID-1:0]    icon_blink;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
        end else if (frame_start) begin
            if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_blink_inputs;
    assign unused_blink_inputs = frame_start ^ wr_blink;
`endif

    // Palette storage; a lookup in the write cycle still sees the old entry.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < WD; i++) world_pal[i] <= world_default(i);
            for (int unsigned i = 0; i < ID; i++) icon_pal[i] <= icon_default(i);
`ifdef PALETTE_COLORIZER_BLINK_EN
            icon_blink <= '0;
`endif
        end else if (wr_en) begin
            if (!wr_sel) begin
                world_pal[wr_addr[WORLD_W-1:0]] <= wr_data;
            end else begin
                icon_pal[wr_addr[ICON_W-1:0]] <= wr_data;
`ifdef PALETTE_COLORIZER_BLINK_EN
                icon_blink[wr_addr[ICON_W-1:0]] <= wr_blink;
`endif
            end
        end
    end

    for (genvar k = 0; k < N_ICON; k++) begin : g_icon
        assign icon_code[k] = icon[k*ICON_W +: ICON_W];
`ifdef PALETTE_COLORIZER_BLINK_EN
        assign icon_vis[k] = !(icon_blink[icon_code[k]] && !blink_phase);
`else
        assign icon_vis[k] = 1'b1;
`endif
    end

    // Stage 1: palette lookups
    logic              von_q;
    logic [11:0]       world_color_q;
    logic [11:0]       icon_color_q [N_ICON];
    logic [N_ICON-1:0] icon_valid_q;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            von_q         <= 1'b0;
            world_color_q <= '0;
            icon_valid_q  <= '0;
            for (int unsigned k = 0; k < N_ICON; k++) icon_color_q[k] <= '0;
        end else begin
            von_q         <= video_on;
            world_color_q <= world_pal[world_pixel];
            for (int unsigned k = 0; k < N_ICON; k++) begin
                icon_color_q[k] <= icon_pal[icon_code[k]];
                icon_valid_q[k] <= (icon_code[k] != '0) && icon_vis[k];
            end
        end
    end

    // Stage 2: priority merge, channel 0 wins
    logic [11:0] rgb_d, rgb_q;

    always_comb begin
        rgb_d = world_color_q;
        for (int k = int'(N_ICON) - 1; k >= 0; k--) begin
            if (icon_valid_q[k]) rgb_d = icon_color_q[k];
        end
        if (!von_q) rgb_d = '0;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) rgb_q <= '0;
        else          rgb_q <= rgb_d;
    end

    // Each 4-bit channel is MSB-aligned into an NV-bit output channel.
    for (genvar c = 0; c < 3; c++) begin : g_chan
        assign VGA[c*NV +: NV] = NV'({rgb_q[c*4 +: 4], 8'h00} >> (12 - NV));
    end

endmodule

// File: tb/tb_palette_colorizer.sv
// Self-checking bench for palette_colorizer: vector table, reset and blink sequences
// with a two-stage scoreboard queue.
`ifndef MFP_N_VGA
`define MFP_N_VGA 4
`endif

module tb_palette_colorizer;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        video_on = 1'b0;
    logic        frame_start = 1'b0;
    logic [1:0]  world_pixel = '0;
    logic [7:0]  icon = '0;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [11:0] wr_data = '0;
    logic        wr_blink = 1'b0;
    logic [`MFP_N_VGA*3-1:0] VGA;

    always #5 clock = ~clock;

    palette_colorizer #(
        .WORLD_W(2),
        .ICON_W(4),
        .N_ICON(2),
        .BLINK_FRAMES(2)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .video_on(video_on),
        .frame_start(frame_start),
        .world_pixel(world_pixel),
        .icon(icon),
        .wr_en(wr_en),
        .wr_sel(wr_sel),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_blink(wr_blink),
        .VGA(VGA)
    );

    typedef struct {
        logic        chk;
        logic [11:0] exp;
        int          id;
    } sb_t;

    typedef struct {
        logic        von;
        logic [1:0]  world;
        logic [3:0]  i0;
        logic [3:0]  i1;
        logic        wen;
        logic        wsel;
        logic [3:0]  waddr;
        logic [11:0] wdata;
        logic        wblink;
        logic [11:0] exp;
    } vec_t;

    sb_t  sb[$];
    vec_t vecs[20];
    int   checks = 0;
    int   errors = 0;

    task automatic compare(input logic [11:0] exp, input int id);
        checks++;
        if (VGA !== exp) begin
            errors++;
            $display("FAIL vec%0d: VGA got %h expected %h", id, VGA, exp);
        end
    endtask

    // One pixel clock: drive, enqueue the expectation, compare what leaves stage 2.
    task automatic step(input logic von, input logic fs, input logic [1:0] w,
                        input logic [3:0] i0, input logic [3:0] i1, input logic wen,
                        input logic wsel, input logic [3:0] wa, input logic [11:0] wd,
                        input logic wb, input logic chk, input logic [11:0] exp, input int id);
        sb_t e;
        video_on    = von;
        frame_start = fs;
        world_pixel = w;
        icon        = {i1, i0};
        wr_en       = wen;
        wr_sel      = wsel;
        wr_addr     = wa;
        wr_data     = wd;
        wr_blink    = wb;
        sb.push_back('{chk, exp, id});
        @(posedge clock);
        #1;
        if (sb.size() == 2) begin
            e = sb.pop_front();
            if (e.chk) compare(e.exp, e.id);
        end
    endtask

    task automatic pix(input logic [1:0] w, input logic [3:0] i0, input logic [3:0] i1,
                       input logic [11:0] exp, input int id);
        step(1'b1, 1'b0, w, i0, i1, 1'b0, 1'b0, 4'h0, 12'h000, 1'b0, 1'b1, exp, id);
    endtask

    // Reset with a concurrent icon write that must be discarded.
    task automatic do_reset(input int id);
        reset_n     = 1'b0;
        video_on    = 1'b1;
        frame_start = 1'b0;
        world_pixel = 2'd2;
        icon        = 8'h22;
        wr_en       = 1'b1;
        wr_sel      = 1'b1;
        wr_addr     = 4'd7;
        wr_data     = 12'hFFF;
        wr_blink    = 1'b0;
        sb.delete();
        @(posedge clock);
        #1;
        compare(12'h000, id);
        sb.push_back('{1'b1, 12'h000, id + 1});
        reset_n = 1'b1;
        wr_en   = 1'b0;
    endtask

    function automatic logic [11:0] blink_exp(input int f);
`ifdef PALETTE_COLORIZER_BLINK_EN
        return (((f / 2) % 2) == 0) ? 12'h0F0 : 12'hBBB;
`else
        return (f >= 0) ? 12'h0F0 : 12'h000;
`endif
    endfunction

    initial begin
        // von world i0 i1 wen wsel waddr wdata wblink exp
        vecs[0]  = '{1'b1, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 12'hBBB};
        vecs[1]  = '{1'b1, 2'd2, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 12'hF51};
        vecs[2]  = '{1'b1, 2'd3, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 12'hFFF};
        vecs[3]  = '{1'b1, 2'd1, 4'd2, 4'd3, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 12'h0F0};
        vecs[4]  = '{1'b1, 2'd1, 4'd0, 4'd3, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 12'hF00};
        vecs[5]  = '{1'b1, 2'd1, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 12'h000};
        vecs[6]  = '{1'b1, 2'd0, 4'd4, 4'd5, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 12'h3A6};
        vecs[7]  = '{1'b1, 2'd0, 4'd0, 4'd6, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 12'h444};
        vecs[8]  = '{1'b1, 2'd0, 4'd1, 4'd0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 12'h000};
        vecs[9]  = '{1'b1, 2'd0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd7, 12'hABC, 1'b0, 12'hBBB};
        vecs[10] = '{1'b1, 2'd0, 4'd7, 4'd0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 12'hABC};
        vecs[11] = '{1'b1, 2'd0, 4'd2, 4'd0, 1'b1, 1'b1, 4'd2, 12'h123, 1'b0, 12'h0F0};
        vecs[12] = '{1'b1, 2'd0, 4'd2, 4'd0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 12'h123};
        vecs[13] = '{1'b1, 2'd0, 4'd0, 4'd0, 1'b1, 1'b0, 4'd4, 12'h456, 1'b0, 12'hBBB};
        vecs[14] = '{1'b1, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 12'h456};
        vecs[15] = '{1'b0, 2'd0, 4'd2, 4'd0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 12'h000};
        vecs[16] = '{1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd3, 12'h777, 1'b0, 12'h000};
        vecs[17] = '{1'b1, 2'd0, 4'd0, 4'd3, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 12'h777};
        vecs[18] = '{1'b1, 2'd3, 4'd8, 4'd0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 12'h000};
        vecs[19] = '{1'b1, 2'd2, 4'd0, 4'd7, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 12'hABC};

        do_reset(900);
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].von, 1'b0, vecs[i].world, vecs[i].i0, vecs[i].i1, vecs[i].wen,
                 vecs[i].wsel, vecs[i].waddr, vecs[i].wdata, vecs[i].wblink, 1'b1,
                 vecs[i].exp, i);
        end

        // Mid-stream reset restores defaults and drops the concurrent write.
        pix(2'd0, 4'd7, 4'd0, 12'hABC, 100);
        pix(2'd0, 4'd7, 4'd0, 12'hABC, 101);
        do_reset(910);
        pix(2'd0, 4'd7, 4'd0, 12'h000, 102);
        pix(2'd0, 4'd2, 4'd0, 12'h0F0, 103);
        pix(2'd0, 4'd0, 4'd0, 12'hBBB, 104);
        pix(2'd1, 4'd0, 4'd3, 12'hF00, 105);

        // Blink: entry 2 marked blinking, one frame_start cycle per frame after frame 0.
        step(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b1, 1'b1, 4'd2, 12'h0F0, 1'b1, 1'b1, 12'h000, 200);
        for (int f = 0; f < 6; f++) begin
            if (f > 0) begin
                step(1'b0, 1'b1, 2'd0, 4'd2, 4'd0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 1'b1,
                     12'h000, 300 + f);
            end
            for (int p = 0; p < 3; p++) pix(2'd0, 4'd2, 4'd0, blink_exp(f), 400 + f * 10 + p);
        end
        step(1'b0, 1'b0, 2'd0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 12'h000, 1'b0, 1'b0, 12'h000, 999);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
